// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants for the decode stage.
//   RV_XLEN       default datapath width
//   RV_NOP_INSTR  addi x0,x0,0; what the IF/ID register holds after reset/flush
//   OPC_*         major opcodes (instr[6:0])
//   imm_fmt_e     immediate format selected by opcode
//   imm_fmt_of()  opcode -> immediate format
package riscv_pkg;

  localparam int          RV_XLEN      = 32;
  localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: fmt = IMM_I;
      OPC_STORE:                      fmt = IMM_S;
      OPC_BRANCH:                     fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
      OPC_JAL:                        fmt = IMM_J;
      default:                        fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/register_file.sv
// 32 x XLEN integer register file, two combinational read ports, one write port.
//   clk, rst_n          clock, asynchronous active-low reset (clears all registers)
//   we_i, waddr_i, wdata_i    write port (writes to x0 are dropped)
//   raddr1_i/raddr2_i   read addresses
//   rdata1_o/rdata2_o   read data; x0 reads 0, a same-cycle write to the read
//                       address is forwarded so decode sees the new value
module register_file
  import riscv_pkg::*;
#(
  parameter int XLEN = RV_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  // Entry 0 is never written, so it stays at its reset value and folds away.
  logic [XLEN-1:0] regs_q [32];
  logic            wr_en;

  assign wr_en = we_i && (waddr_i != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = '0;
    if (raddr1_i == 5'd0)                rdata1_o = '0;
    else if (wr_en && waddr_i == raddr1_i) rdata1_o = wdata_i;
    else                                 rdata1_o = regs_q[raddr1_i];
  end

  always_comb begin
    rdata2_o = '0;
    if (raddr2_i == 5'd0)                rdata2_o = '0;
    else if (wr_en && waddr_i == raddr2_i) rdata2_o = wdata_i;
    else                                 rdata2_o = regs_q[raddr2_i];
  end

endmodule

// File: rtl/stage_id.sv
// Instruction-decode stage: IF/ID pipeline register, register file, field
// extraction, immediate generation and load-use hazard detection.
//   Inputs : clk, rst_n, pc_in, pc_plus_4_in, instruction_in (from fetch),
//            flush, ex_mem_read, ex_rd (from EX), wb_reg_write, wb_rd, wb_data.
//   Outputs: pc_write (to fetch), bubble (to ID/EX), valid_id, pc_id,
//            pc_plus_4_id, opcode, funct3, funct7, rs1, rs2, rd, rs1_data,
//            rs2_data, imm -- all combinational from the IF/ID register.
// Flow control: fetch may advance only when pc_write=1. When a stall is
// raised the IF/ID register holds and ID/EX must take a bubble; flush beats
// stall and squashes IF/ID to a NOP with valid_id=0.
module stage_id
  import riscv_pkg::*;
#(
  parameter int          XLEN      = RV_XLEN,
  parameter logic [31:0] NOP_INSTR = RV_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] pc_plus_4_in,
  input  logic [31:0]     instruction_in,
  input  logic            flush,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            pc_write,
  output logic            bubble,
  output logic            valid_id,
  output logic [XLEN-1:0] pc_id,
  output logic [XLEN-1:0] pc_plus_4_id,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm
);

  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;
  logic            stall;
  logic            uses_rs1, uses_rs2;

  // IF/ID register next state: flush > stall > load.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = instruction_in;
      pc_d    = pc_in;
      pc4_d   = pc_plus_4_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign opcode       = instr_q[6:0];
  assign rd           = instr_q[11:7];
  assign funct3       = instr_q[14:12];
  assign rs1          = instr_q[19:15];
  assign rs2          = instr_q[24:20];
  assign funct7       = instr_q[31:25];
  assign valid_id     = valid_q;
  assign pc_id        = pc_q;
  assign pc_plus_4_id = pc4_q;

  // Only real source operands may cause a stall; U/J formats reuse those bits.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_OP, OPC_STORE, OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  // One stall cycle suffices: next cycle the load has moved on to MEM.
  assign stall = ex_mem_read && (ex_rd != 5'd0) && valid_q &&
                 ((uses_rs1 && ex_rd == rs1) || (uses_rs2 && ex_rd == rs2));

  assign pc_write = !stall || flush;
  assign bubble   = stall || !valid_q;

  always_comb begin
    imm = '0;
    case (imm_fmt_of(opcode))
      IMM_I: imm = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
      IMM_S: imm = {{(XLEN-12){instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      IMM_B: imm = {{(XLEN-13){instr_q[31]}}, instr_q[31], instr_q[7],
                    instr_q[30:25], instr_q[11:8], 1'b0};
      IMM_U: imm = {{(XLEN-32){instr_q[31]}}, instr_q[31:12], 12'b0};
      IMM_J: imm = {{(XLEN-21){instr_q[31]}}, instr_q[31], instr_q[19:12],
                    instr_q[20], instr_q[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  register_file #(.XLEN(XLEN)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (wb_reg_write),
    .waddr_i  (wb_rd),
    .wdata_i  (wb_data),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data)
  );

endmodule

// File: tb/tb_stage_id.sv
module tb_stage_id;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_in, pc_plus_4_in, instruction_in;
  logic        flush, ex_mem_read;
  logic [4:0]  ex_rd;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        pc_write, bubble, valid_id;
  logic [31:0] pc_id, pc_plus_4_id;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1_data, rs2_data, imm;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_imm_q[$];
  logic [31:0] exp_pc_q[$];

  stage_id dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_in          (pc_in),
    .pc_plus_4_in   (pc_plus_4_in),
    .instruction_in (instruction_in),
    .flush          (flush),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .wb_reg_write   (wb_reg_write),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .pc_write       (pc_write),
    .bubble         (bubble),
    .valid_id       (valid_id),
    .pc_id          (pc_id),
    .pc_plus_4_id   (pc_plus_4_id),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7),
    .rs1            (rs1),
    .rs2            (rs2),
    .rd             (rd),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .imm            (imm)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    return {7'b0, s2, s1, 3'b000, d, 7'b0110011};
  endfunction

  task automatic wb_write(input logic [4:0] r, input logic [31:0] v);
    wb_reg_write = 1'b1;
    wb_rd        = r;
    wb_data      = v;
    step();
    wb_reg_write = 1'b0;
  endtask

  // Reference immediate, built with shifts/masks straight from the ISA layout.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic [31:0] s;
    logic [6:0]  op;
    op = ins & 32'h7F;
    s  = ins & 32'h8000_0000;
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: return 32'($signed(ins) >>> 20);
      7'b0100011: return 32'($signed(ins & 32'hFE00_0000) >>> 20) | ((ins >> 7) & 32'h1F);
      7'b1100011: return 32'($signed(s) >>> 19) | ((ins >> 20) & 32'h7E0) |
                         ((ins >> 7) & 32'h1E) | ((ins << 4) & 32'h800);
      7'b0110111, 7'b0010111: return ins & 32'hFFFF_F000;
      7'b1101111: return 32'($signed(s) >>> 11) | (ins & 32'h000F_F000) |
                         ((ins >> 9) & 32'h800) | ((ins >> 20) & 32'h7FE);
      default: return 32'h0;
    endcase
  endfunction

  // Drive one fetched instruction and record what IF/ID must show next cycle.
  task automatic fetch_push(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] exp_imm);
    instruction_in = ins;
    pc_in          = pc;
    pc_plus_4_in   = pc + 32'd4;
    exp_q.push_back(ins);
    exp_imm_q.push_back(exp_imm);
    exp_pc_q.push_back(pc);
  endtask

  // scoreboard: compare once IF/ID has captured the instruction
  task automatic sb_compare();
    logic [31:0] e_ins, e_imm, e_pc;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      return;
    end
    e_ins = exp_q.pop_front();
    e_imm = exp_imm_q.pop_front();
    e_pc  = exp_pc_q.pop_front();
    check("sb_instr", {funct7, rs2, rs1, funct3, rd, opcode}, e_ins);
    check("sb_imm", imm, e_imm);
    check("sb_pc", pc_id, e_pc);
    check("sb_pc4", pc_plus_4_id, e_pc + 32'd4);
    check("sb_valid", {31'd0, valid_id}, 32'd1);
  endtask

  logic [6:0] ops [10];

  initial begin
    rst_n = 1'b0; pc_in = '0; pc_plus_4_in = '0; instruction_in = 32'h13;
    flush = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
    wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
    repeat (2) step();
    rst_n = 1'b1;

    // Reset asserted mid-cycle after real traffic
    instruction_in = mk_r(3, 4, 5); pc_in = 32'h40; pc_plus_4_in = 32'h44;
    step();
    check("pre_rst_valid", {31'd0, valid_id}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_instr", {funct7, rs2, rs1, funct3, rd, opcode}, 32'h0000_0013);
    check("rst_valid", {31'd0, valid_id}, 32'd0);
    check("rst_pc_write", {31'd0, pc_write}, 32'd1);
    check("rst_bubble", {31'd0, bubble}, 32'd1);
    check("rst_pc", pc_id, 32'd0);
    check("rst_pc4", pc_plus_4_id, 32'd0);
    check("rst_imm", imm, 32'd0);
    step();
    rst_n = 1'b1;

    // Every register reads zero after reset
    for (int i = 1; i < 32; i++) begin
      instruction_in = mk_r(5'd0, 5'(i), 5'(i));
      step();
      check($sformatf("rst_x%0d_a", i), rs1_data, 32'd0);
      check($sformatf("rst_x%0d_b", i), rs2_data, 32'd0);
    end

    // Writeback bypass, then the stored value
    instruction_in = mk_r(6, 5, 5);
    step();
    wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
    #1;
    check("byp_rs1", rs1_data, 32'hDEAD_BEEF);
    check("byp_rs2", rs2_data, 32'hDEAD_BEEF);
    step();
    wb_reg_write = 1'b0;
    #1;
    check("arr_rs1", rs1_data, 32'hDEAD_BEEF);
    check("arr_rs2", rs2_data, 32'hDEAD_BEEF);

    // x0 write is ignored
    instruction_in = mk_r(1, 0, 0);
    step();
    wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    #1;
    check("x0_byp", rs1_data, 32'd0);
    step();
    wb_reg_write = 1'b0;
    #1;
    check("x0_arr", rs1_data, 32'd0);

    // Load-use stall: exactly one held cycle
    wb_write(5'd1, 32'h11);
    instruction_in = mk_r(8, 7, 1); pc_in = 32'h100; pc_plus_4_in = 32'h104;
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd7;
    instruction_in = mk_r(9, 2, 3); pc_in = 32'h104; pc_plus_4_in = 32'h108;
    #1;
    check("lu_pc_write", {31'd0, pc_write}, 32'd0);
    check("lu_bubble", {31'd0, bubble}, 32'd1);
    step();
    ex_mem_read = 1'b0;
    #1;
    check("lu_hold_rd", {27'd0, rd}, 32'd8);
    check("lu_hold_pc", pc_id, 32'h100);
    check("lu_hold_rs2d", rs2_data, 32'h11);
    check("lu_rel_pc_write", {31'd0, pc_write}, 32'd1);
    check("lu_rel_bubble", {31'd0, bubble}, 32'd0);
    step();
    check("lu_adv_rd", {27'd0, rd}, 32'd9);
    check("lu_adv_pc", pc_id, 32'h104);

    // No stall when the load targets x0, nor for an rs1 field that is not a source
    instruction_in = mk_r(9, 0, 3);
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd0;
    #1;
    check("nohz_x0", {31'd0, pc_write}, 32'd1);
    ex_mem_read = 1'b0;
    instruction_in = 32'h0003_82B7;  // lui x5 with bits[19:15]=7
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd7;
    #1;
    check("nohz_lui", {31'd0, pc_write}, 32'd1);
    ex_mem_read = 1'b0;
    instruction_in = 32'h0070_2023;  // sw x7,0(x0): rs2 hazard
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd7;
    #1;
    check("hz_store_rs2", {31'd0, pc_write}, 32'd0);
    ex_mem_read = 1'b0;

    // Flush wins over stall
    instruction_in = mk_r(8, 7, 1);
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd7; flush = 1'b1;
    #1;
    check("fl_pc_write", {31'd0, pc_write}, 32'd1);
    step();
    flush = 1'b0; ex_mem_read = 1'b0;
    #1;
    check("fl_instr", {funct7, rs2, rs1, funct3, rd, opcode}, 32'h0000_0013);
    check("fl_valid", {31'd0, valid_id}, 32'd0);
    check("fl_pc_write2", {31'd0, pc_write}, 32'd1);
    check("fl_bubble", {31'd0, bubble}, 32'd1);

    // Reset in the middle of a stall
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd7;
    #1;
    check("rs_stall", {31'd0, pc_write}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rs_valid", {31'd0, valid_id}, 32'd0);
    check("rs_pc_write", {31'd0, pc_write}, 32'd1);
    check("rs_opcode", {25'd0, opcode}, 32'h13);
    step();
    rst_n = 1'b1; ex_mem_read = 1'b0;
    instruction_in = mk_r(6, 5, 5);
    step();
    check("rs_x5_cleared", rs1_data, 32'd0);
    check("rs_valid_after", {31'd0, valid_id}, 32'd1);

    // Immediates through the scoreboard
    fetch_push(32'hFE01_0113, 32'h200, 32'hFFFF_FFE0);  // addi x2,x2,-32
    step(); sb_compare();
    fetch_push(32'hFE00_0EE3, 32'h204, 32'hFFFF_FFFC);  // beq x0,x0,-4
    step(); sb_compare();
    fetch_push(32'h0000_12B7, 32'h208, 32'h0000_1000);  // lui x5,1
    step(); sb_compare();
    fetch_push(32'h8000_006F, 32'h20C, 32'hFFF0_0000);  // jal x0, most negative
    step(); sb_compare();
    fetch_push(mk_r(1, 2, 3), 32'h210, 32'h0);          // R-type: no immediate
    step(); sb_compare();

    ops[0] = 7'b0000011; ops[1] = 7'b0010011; ops[2] = 7'b1100111;
    ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b0110111;
    ops[6] = 7'b0010111; ops[7] = 7'b1101111; ops[8] = 7'b0110011;
    ops[9] = 7'b1110011;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ins;
      ins = {$urandom()} & 32'hFFFF_FF80;
      ins = ins | {25'd0, ops[$urandom_range(0, 9)]};
      fetch_push(ins, 32'h1000 + 32'(4 * i), ref_imm(ins));
      step(); sb_compare();
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
